// File: rtl/seq_hit_monitor.sv
// Monitor for a serial 1010 detector output: counts rising edges of hit, tracks
// detections per time window and latches an alarm when a window reaches the threshold.
module seq_hit_monitor #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             clear,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] hit_thresh,
  output logic             hit_pulse,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] win_hits,
  output logic             alarm,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    ALARM  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state_reg, state_next;
  logic             hit_d_reg;
  logic             hit_pulse_reg;
  logic             alarm_reg;
  logic             busy_reg;
  logic [CNT_W-1:0] hit_cnt_reg, hit_cnt_next;
  logic [CNT_W-1:0] win_hits_reg, win_hits_next;
  logic [WIN_W-1:0] win_timer_reg, win_timer_next;

  logic             hit_edge;
  logic [WIN_W-1:0] len_m1;
  logic [CNT_W-1:0] win_hits_inc;
  logic             thresh_reached;

  assign hit_edge       = hit & ~hit_d_reg;
  // A zero length behaves like a one-cycle window, so the reload value is 0 in both cases.
  assign len_m1         = (win_len == '0) ? '0 : (win_len - WIN_ONE);
  assign win_hits_inc   = (win_hits_reg == CNT_MAX) ? win_hits_reg : (win_hits_reg + CNT_ONE);
  assign thresh_reached = (hit_thresh != '0) && (win_hits_inc >= hit_thresh);

  always_comb begin
    state_next     = state_reg;
    win_hits_next  = win_hits_reg;
    win_timer_next = win_timer_reg;
    hit_cnt_next   = hit_cnt_reg;
    if (hit_edge && (hit_cnt_reg != CNT_MAX)) begin
      hit_cnt_next = hit_cnt_reg + CNT_ONE;
    end

    if (clear) begin
      state_next     = IDLE;
      win_hits_next  = '0;
      win_timer_next = '0;
      hit_cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (hit_edge) begin
            win_hits_next = CNT_ONE;
            if (hit_thresh == CNT_ONE) begin
              state_next = ALARM;
            end else begin
              state_next     = WINDOW;
              win_timer_next = len_m1;
            end
          end
        end
        WINDOW: begin
          // An edge on the expiry cycle is credited to the expiring window before any reopen.
          if (hit_edge && thresh_reached) begin
            state_next    = ALARM;
            win_hits_next = win_hits_inc;
          end else if (win_timer_reg == '0) begin
            if (hit_edge) begin
              win_hits_next  = CNT_ONE;
              win_timer_next = len_m1;
            end else begin
              state_next    = IDLE;
              win_hits_next = '0;
            end
          end else begin
            win_timer_next = win_timer_reg - WIN_ONE;
            if (hit_edge) begin
              win_hits_next = win_hits_inc;
            end
          end
        end
        ALARM: begin
          state_next = ALARM;
        end
        default: begin
          state_next     = IDLE;
          win_hits_next  = '0;
          win_timer_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      hit_d_reg     <= 1'b0;
      hit_pulse_reg <= 1'b0;
      hit_cnt_reg   <= '0;
      win_hits_reg  <= '0;
      win_timer_reg <= '0;
      alarm_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hit_d_reg     <= hit;
      hit_pulse_reg <= hit_edge & ~clear;
      hit_cnt_reg   <= hit_cnt_next;
      win_hits_reg  <= win_hits_next;
      win_timer_reg <= win_timer_next;
      alarm_reg     <= (state_next == ALARM);
      busy_reg      <= (state_next == WINDOW);
    end
  end

  assign hit_pulse = hit_pulse_reg;
  assign hit_cnt   = hit_cnt_reg;
  assign win_hits  = win_hits_reg;
  assign alarm     = alarm_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Directed and randomized bench for seq_hit_monitor against a cycle-count based window model.
module tb_seq_hit_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       hit = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] win_len = 8'd1;
  logic [7:0] hit_thresh = 8'd0;
  logic       hit_pulse;
  logic [7:0] hit_cnt;
  logic [7:0] win_hits;
  logic       alarm;
  logic       busy;

  int compared = 0;
  int mismatched = 0;

  // Reference model: windows tracked as absolute expiry cycle numbers.
  int     m_cnt, m_win;
  bit     m_alarm, m_open, m_pulse, m_prev;
  longint m_cyc, m_deadline;

  // Behavioural 1010 detector feeding hit in the detector-driven scenario.
  logic [3:0] det_sr = 4'd0;
  logic       det_q = 1'b0;

  seq_hit_monitor #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .reset(reset), .hit(hit), .clear(clear),
    .win_len(win_len), .hit_thresh(hit_thresh),
    .hit_pulse(hit_pulse), .hit_cnt(hit_cnt), .win_hits(win_hits),
    .alarm(alarm), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_win = 0; m_alarm = 0; m_open = 0; m_pulse = 0; m_prev = 0;
    m_deadline = 0;
  endtask

  task automatic model_step();
    bit e;
    int len;
    m_cyc++;
    if (!reset) begin
      model_reset();
      return;
    end
    e = hit && !m_prev;
    m_prev = hit;
    if (clear) begin
      m_cnt = 0; m_win = 0; m_alarm = 0; m_open = 0; m_pulse = 0;
      return;
    end
    len = (win_len == 0) ? 1 : int'(win_len);
    m_pulse = e;
    if (e && m_cnt < 255) m_cnt++;
    if (m_alarm) begin
      // frozen until clear/reset
    end else if (!m_open) begin
      if (e) begin
        m_win = 1;
        if (hit_thresh == 1) m_alarm = 1;
        else begin m_open = 1; m_deadline = m_cyc + len; end
      end
    end else begin
      if (e && m_win < 255) m_win++;
      if (e && hit_thresh != 0 && m_win >= int'(hit_thresh)) begin
        m_alarm = 1; m_open = 0;
      end else if (m_cyc == m_deadline) begin
        if (e) begin m_win = 1; m_deadline = m_cyc + len; end
        else begin m_open = 0; m_win = 0; end
      end
    end
  endtask

  task automatic check_all();
    chk("hit_pulse", 32'(hit_pulse), 32'(m_pulse));
    chk("hit_cnt", 32'(hit_cnt), 32'(m_cnt));
    chk("win_hits", 32'(win_hits), 32'(m_win));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("busy", 32'(busy), 32'(m_open));
  endtask

  task automatic tick(input logic h, input logic c);
    hit = h;
    clear = c;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_async_reset();
    #3 reset = 1'b0;
    #1 model_reset();
    check_all();
    @(posedge clk);
    model_step();
    #1 check_all();
    reset = 1'b1;
  endtask

  initial begin
    int pulses, first_t, second_t;
    logic [5:0] bits;
    logic b;
    m_cyc = 0;
    model_reset();

    // Reset held for three cycles, then ten idle cycles.
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);

    // Detector-driven: serial 101010 produces two overlapping detections.
    tick(1'b0, 1'b1);
    win_len = 8'd20; hit_thresh = 8'd2;
    bits = 6'b101010;
    pulses = 0; first_t = 0; second_t = 0;
    for (int i = 0; i < 11; i++) begin
      b = (i < 6) ? bits[5 - i] : 1'b0;
      tick(det_q, 1'b0);
      det_sr = {det_sr[2:0], b};
      det_q = (det_sr == 4'b1010);
      if (hit_pulse) begin
        pulses++;
        if (pulses == 1) first_t = i; else second_t = i;
        if (pulses == 2) chk("det_alarm_on_2nd", 32'(alarm), 32'd1);
      end
    end
    chk("det_pulses", 32'(pulses), 32'd2);
    chk("det_gap", 32'(second_t - first_t), 32'd2);
    chk("det_cnt", 32'(hit_cnt), 32'd2);
    chk("det_busy", 32'(busy), 32'd0);

    // Window expiry: edges at cycles 0 and 6 with a 4-cycle window.
    tick(1'b0, 1'b1);
    win_len = 8'd4; hit_thresh = 8'd3;
    for (int i = 0; i < 8; i++) begin
      tick((i == 0) || (i == 6), 1'b0);
      if (i == 4) begin
        chk("exp_busy_c4", 32'(busy), 32'd0);
        chk("exp_win_c4", 32'(win_hits), 32'd0);
      end
      if (i == 6) chk("exp_win_c6", 32'(win_hits), 32'd1);
    end
    chk("exp_alarm", 32'(alarm), 32'd0);
    chk("exp_cnt", 32'(hit_cnt), 32'd2);

    // Edge coincident with expiry: alarm at threshold 2, reopen at threshold 3.
    tick(1'b0, 1'b1);
    win_len = 8'd3; hit_thresh = 8'd2;
    for (int i = 0; i < 4; i++) tick((i == 0) || (i == 3), 1'b0);
    chk("coin_alarm", 32'(alarm), 32'd1);
    tick(1'b0, 1'b1);
    hit_thresh = 8'd3;
    for (int i = 0; i < 4; i++) tick((i == 0) || (i == 3), 1'b0);
    chk("coin_noalarm", 32'(alarm), 32'd0);
    chk("coin_reopen_win", 32'(win_hits), 32'd1);
    chk("coin_reopen_busy", 32'(busy), 32'd1);

    // Level hit counts once.
    tick(1'b0, 1'b1);
    hit_thresh = 8'd0; win_len = 8'd5;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      tick(i < 5, 1'b0);
      if (hit_pulse) pulses++;
    end
    chk("level_pulses", 32'(pulses), 32'd1);
    chk("level_cnt", 32'(hit_cnt), 32'd1);

    // Saturation of the total counter.
    for (int i = 0; i < 300; i++) begin
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
    chk("sat_cnt", 32'(hit_cnt), 32'd255);
    tick(1'b1, 1'b0);
    chk("sat_hold", 32'(hit_cnt), 32'd255);

    // Clear beats a same-cycle edge while in ALARM.
    tick(1'b0, 1'b1);
    hit_thresh = 8'd1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("alarm_set", 32'(alarm), 32'd1);
    tick(1'b1, 1'b1);
    chk("clr_cnt", 32'(hit_cnt), 32'd0);
    chk("clr_alarm", 32'(alarm), 32'd0);
    chk("clr_pulse", 32'(hit_pulse), 32'd0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);

    // Asynchronous reset between clock edges inside an open window.
    hit_thresh = 8'd0; win_len = 8'd20;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    chk("mid_busy", 32'(busy), 32'd1);
    do_async_reset();

    // Randomized traffic with live parameter changes, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 40 == 0) begin
        win_len = 8'($urandom_range(0, 9));
        hit_thresh = 8'($urandom_range(0, 6));
      end
      if ($urandom % 400 == 0) do_async_reset();
      else tick(($urandom % 3) == 0, ($urandom % 60) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_hit_monitor.md
Name: seq_hit_monitor

Overview:
- Downstream consumer of the serial 1010 sequence detector's Moore output `q`, wired to this block's `hit` input.
- Counts detections, measures detection rate over a fixed window of cycles, and raises a sticky alarm when too many detections fall inside one window.
- Its outputs feed status/interrupt logic.

Parameters:
- CNT_W, 8, width of the total detection counter and of the threshold.
- WIN_W, 8, width of the window length and of the window timer.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- hit  input  1  detector output `q`; level, sampled every clk.
- clear  input  1  synchronous clear of counters, window and alarm.
- win_len  input  WIN_W  window length in cycles; 0 is treated as 1.
- hit_thresh  input  CNT_W  detections per window that trigger the alarm; 0 disables the alarm.
- hit_pulse  output  1  registered single-cycle pulse per detected rising edge of hit.
- hit_cnt  output  CNT_W  total detections since reset/clear; saturates at all-ones.
- win_hits  output  CNT_W  detections in the current window; saturates.
- alarm  output  1  sticky alarm flag.
- busy  output  1  high while a window is open (state WINDOW).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hit_d=0, hit_pulse=0, hit_cnt=0, win_hits=0, win_timer=0, alarm=0, busy=0.
- Edge detect:
  - hit_d registers hit every cycle, including during clear.
  - A detection is defined as edge = hit & ~hit_d.
  - hit held high for several cycles counts once.
- Latency: all outputs are registered. For a hit edge sampled at clock edge k, hit_pulse, hit_cnt, win_hits and alarm all update at edge k.
- hit_cnt: increments by 1 on every edge unless it equals all-ones; it continues counting in every state.
- Effective length: L = (win_len==0) ? 1 : win_len, sampled when a window opens.
- FSM states: IDLE, WINDOW, ALARM.
- IDLE:
  - On edge: win_hits=1.
  - If hit_thresh==1 → ALARM.
  - Otherwise → WINDOW with win_timer=L-1. If L==1, the window expires next cycle.
- WINDOW:
  - Each cycle win_timer decrements; busy=1.
  - On edge: win_hits+1 (saturating). If the new value ≥ hit_thresh and hit_thresh≠0 → ALARM.
  - Expiry (win_timer==0 at this edge) with no edge → IDLE, win_hits=0.
  - Expiry with a simultaneous edge: the edge counts in the expiring window first. If that reaches the threshold → ALARM. Otherwise a new window opens immediately: stay in WINDOW, win_hits=1, win_timer=L-1.
- ALARM:
  - alarm=1, busy=0.
  - win_hits holds its value; no further window processing.
  - Exits only via clear or reset.
- hit_thresh==0: alarm is never raised; windows open, count and expire normally.
- clear=1 (synchronous):
  - Next state IDLE; hit_cnt=0, win_hits=0, win_timer=0, alarm=0, hit_pulse=0.
  - clear has priority over a same-cycle edge; that edge is dropped.
- Reset mid-window or while in ALARM: all state and outputs return to reset values immediately, without waiting for clk.
- win_len and hit_thresh may change at any time. win_len takes effect at the next window open; hit_thresh is compared live.
- No default-state lockup: any unused state encoding → IDLE.

Test Plan:
- Reset/idle: reset=0 for 3 cycles, then 1; hit=0 for 10 cycles → hit_cnt=0, win_hits=0, alarm=0, busy=0 throughout.
- Driven by the detector:
  - Serial input 1,0,1,0,1,0 is fed to the detector; its q drives hit.
  - win_len=20, hit_thresh=2.
  - → two hit_pulse events, two cycles apart; hit_cnt=2; alarm=1 on the second pulse edge; busy=0 afterwards.
- Window expiry: win_len=4, hit_thresh=3; hit edges at cycles 0 and 6 → after cycle 4 state IDLE, win_hits=0; at cycle 6 win_hits=1; alarm stays 0; hit_cnt=2.
- Expiry coincidence: win_len=3, hit_thresh=2; edges at cycle 0 and at the expiry cycle 3 → alarm=1 at cycle 3. Repeat with hit_thresh=3 → no alarm, new window opened with win_hits=1.
- Level hit and saturation:
  - hit held high for 5 cycles → exactly one hit_pulse, hit_cnt+1.
  - With CNT_W=8 and 300 separated edges → hit_cnt=255 and holds.
- Clear vs edge and async reset:
  - clear=1 in the same cycle as an edge while in ALARM → hit_cnt=0, alarm=0, IDLE, no hit_pulse.
  - reset=0 asserted between clock edges mid-window → outputs 0 before the next clk edge.
